// File: rtl/stat_key_probe_if.sv
// Bundle of the run-control, readback and circuit-under-test signals of the key-probe harness.
// The slave modport is the harness side; the master modport is the controller/environment side.
interface stat_key_probe_if #(
  parameter int IN_W  = 32,
  parameter int KEY_W = 128,
  parameter int OUT_W = 22,
  parameter int CNT_W = 16
);
  localparam int IDX_W = $clog2(KEY_W);

  logic                start;
  logic [CNT_W-1:0]    trials;
  logic [31:0]         seed;
  logic [IN_W-1:0]     dut_in;
  logic [KEY_W-1:0]    dut_key;
  logic [OUT_W-1:0]    dut_out;
  logic [OUT_W-1:0]    oracle_out;
  logic                busy;
  logic                done;
  logic [CNT_W-1:0]    match_cnt;
  logic [KEY_W-1:0]    key_guess;
  logic [IDX_W-1:0]    rd_idx;
  logic [CNT_W-1:0]    rd_hit;

  modport slave (
    input  start, trials, seed, dut_out, oracle_out, rd_idx,
    output dut_in, dut_key, busy, done, match_cnt, key_guess, rd_hit
  );

  modport master (
    output start, trials, seed, dut_out, oracle_out, rd_idx,
    input  dut_in, dut_key, busy, done, match_cnt, key_guess, rd_hit
  );
endinterface

// File: rtl/stat_key_probe.sv
// Statistical key probe: drives LFSR-generated input/key vectors into a locked circuit and its
// oracle, counts matching trials and per-key-bit hits, and forms a majority key guess.
module stat_key_probe #(
  parameter int IN_W   = 32,
  parameter int KEY_W  = 128,
  parameter int OUT_W  = 22,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic              v_in1_v,
  input  logic              reset,
  stat_key_probe_if.slave   bus
);
  localparam int WORDS = (IN_W + KEY_W + 31) / 32;
  localparam int VW    = WORDS * 32;
  localparam int PH_W  = 8;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {S_IDLE, S_GEN, S_SETTLE, S_SAMPLE, S_FINAL} state_t;

  state_t           state, state_nx;
  logic [PH_W-1:0]  ph;
  logic [CNT_W-1:0] trials_q;
  logic [CNT_W-1:0] trial_cnt;
  logic [31:0]      lfsr;
  logic [VW-33:0]   vec_q;
  logic [VW-1:0]    vec_full;
  logic [CNT_W-1:0] hit [KEY_W];
  logic             match;
  logic             gen_last;
  logic             settle_last;
  logic             last_trial;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 32'h0);
  endfunction

  // The word generated this cycle completes the vector, so the last GEN cycle loads it directly.
  assign vec_full    = {lfsr, vec_q};
  assign match       = (bus.dut_out == bus.oracle_out);
  assign gen_last    = (ph == PH_W'(WORDS - 1));
  assign settle_last = (ph == PH_W'(SETTLE - 1));
  assign last_trial  = (({1'b0, trial_cnt} + (CNT_W+1)'(1)) == {1'b0, trials_q});

  always_ff @(posedge v_in1_v or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (bus.start) state_nx = (bus.trials == '0) ? S_FINAL : S_GEN;
      S_GEN:    if (gen_last) state_nx = S_SETTLE;
      S_SETTLE: if (settle_last) state_nx = S_SAMPLE;
      S_SAMPLE: state_nx = last_trial ? S_FINAL : S_GEN;
      S_FINAL:  state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Vector assembly shift register; contents are only meaningful during GEN.
  always_ff @(posedge v_in1_v) begin
    if (state == S_GEN) vec_q <= vec_full[VW-1:32];
  end

  always_ff @(posedge v_in1_v or negedge reset) begin
    if (!reset) begin
      ph            <= '0;
      trials_q      <= '0;
      trial_cnt     <= '0;
      lfsr          <= 32'h1;
      bus.dut_in    <= '0;
      bus.dut_key   <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.match_cnt <= '0;
      bus.key_guess <= '0;
      bus.rd_hit    <= '0;
      for (int i = 0; i < KEY_W; i++) hit[i] <= '0;
    end else begin
      bus.done   <= 1'b0;
      bus.rd_hit <= hit[bus.rd_idx];
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            trials_q      <= bus.trials;
            lfsr          <= (bus.seed == 32'h0) ? 32'h1 : bus.seed;
            trial_cnt     <= '0;
            bus.match_cnt <= '0;
            ph            <= '0;
            bus.busy      <= 1'b1;
            for (int i = 0; i < KEY_W; i++) hit[i] <= '0;
          end
        end
        S_GEN: begin
          lfsr <= lfsr_step(lfsr);
          if (gen_last) begin
            ph          <= '0;
            bus.dut_in  <= vec_full[IN_W-1:0];
            bus.dut_key <= vec_full[IN_W+KEY_W-1:IN_W];
          end else begin
            ph <= ph + PH_W'(1);
          end
        end
        S_SETTLE: begin
          ph <= settle_last ? '0 : ph + PH_W'(1);
        end
        S_SAMPLE: begin
          trial_cnt <= trial_cnt + CNT_W'(1);
          if (match) begin
            bus.match_cnt <= bus.match_cnt + CNT_W'(1);
            for (int i = 0; i < KEY_W; i++)
              if (bus.dut_key[i]) hit[i] <= hit[i] + CNT_W'(1);
          end
        end
        S_FINAL: begin
          // Strict majority of matching trials; ties and zero matches resolve to 0.
          for (int i = 0; i < KEY_W; i++)
            bus.key_guess[i] <= ({hit[i], 1'b0} > {1'b0, bus.match_cnt});
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_stat_key_probe.sv
// Directed bench for stat_key_probe: table of runs checked against a reference model of the
// LFSR vector stream, plus hand sequences for reset and mid-run abort/replay.
module tb_stat_key_probe;
  localparam int IN_W = 32, KEY_W = 128, OUT_W = 22, SETTLE = 2, CNT_W = 16;
  localparam int WORDS = (IN_W + KEY_W + 31) / 32;
  localparam int TRIAL_CYC = WORDS + SETTLE + 1;
  localparam int NV = 6;

  logic clk = 1'b0;
  logic rst_n;
  int   mode = 0;
  int   errors = 0;
  int   checks = 0;
  logic [OUT_W-1:0] orc;

  always #5 clk = ~clk;

  stat_key_probe_if #(.IN_W(IN_W), .KEY_W(KEY_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) bus();

  stat_key_probe #(.IN_W(IN_W), .KEY_W(KEY_W), .OUT_W(OUT_W), .SETTLE(SETTLE), .CNT_W(CNT_W))
    dut (.v_in1_v(clk), .reset(rst_n), .bus(bus));

  // Environment: oracle is a fixed function of the vector; the locked circuit deviates per mode.
  always_comb begin
    orc = bus.dut_in[OUT_W-1:0] ^ bus.dut_key[OUT_W-1:0];
    bus.oracle_out = orc;
    case (mode)
      1:       bus.dut_out = orc ^ {OUT_W{~bus.dut_key[5]}};
      2:       bus.dut_out = ~orc;
      default: bus.dut_out = orc;
    endcase
  end

  typedef struct {
    int               trials;
    logic [31:0]      seed;
    int               mode;
    int               exp_match;
    logic [KEY_W-1:0] exp_guess;
    logic [IN_W-1:0]  exp_in;
    logic [KEY_W-1:0] exp_key;
  } vec_t;

  vec_t tv[NV];
  int   exp_hit[NV][KEY_W];

  int               m_match;
  int               m_hit[KEY_W];
  logic [KEY_W-1:0] m_guess;
  logic [IN_W-1:0]  m_in;
  logic [KEY_W-1:0] m_key;

  task automatic check(input string name, input logic [KEY_W-1:0] act, input logic [KEY_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_step(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  task automatic model(input int trials, input logic [31:0] seed, input int md);
    logic [31:0]         s;
    logic [WORDS*32-1:0] v;
    logic [OUT_W-1:0]    o, d;
    s = (seed == 32'h0) ? 32'h1 : seed;
    v = '0;
    m_match = 0;
    m_in = '0;
    m_key = '0;
    for (int i = 0; i < KEY_W; i++) m_hit[i] = 0;
    for (int t = 0; t < trials; t++) begin
      for (int w = 0; w < WORDS; w++) begin
        v[32*w +: 32] = s;
        s = ref_step(s);
      end
      m_in  = v[IN_W-1:0];
      m_key = v[IN_W+KEY_W-1:IN_W];
      o = m_in[OUT_W-1:0] ^ m_key[OUT_W-1:0];
      d = (md == 1) ? (o ^ {OUT_W{~m_key[5]}}) : (md == 2) ? ~o : o;
      if (d == o) begin
        m_match++;
        for (int i = 0; i < KEY_W; i++) if (m_key[i]) m_hit[i]++;
      end
    end
    for (int i = 0; i < KEY_W; i++) m_guess[i] = (2 * m_hit[i] > m_match);
  endtask

  // Issues a start, checks busy rises, and waits (bounded) for done; cyc counts edges after start.
  task automatic start_and_wait(input int trials, input logic [31:0] seed, output int cyc);
    int limit;
    limit = trials * TRIAL_CYC + 20;
    @(negedge clk);
    bus.trials = CNT_W'(trials);
    bus.seed   = seed;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    cyc = 0;
    while (!bus.done && cyc < limit) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    int          cyc;
    bit          done_seen;
    logic [IN_W-1:0]  cap_in;
    logic [KEY_W-1:0] cap_key;

    tv[0] = '{0,   32'd5,          0, 0,  '0, '0, '0};
    tv[1] = '{10,  32'h0000_ACE1,  0, 10, '0, '0, '0};
    tv[2] = '{256, 32'h0000_ACE1,  1, -1, '0, '0, '0};
    tv[3] = '{20,  32'h1234_5678,  2, 0,  '0, '0, '0};
    tv[4] = '{3,   32'h0,          0, 3,  '0, '0, '0};
    tv[5] = '{5,   32'hDEAD_BEEF,  1, -1, '0, '0, '0};
    for (int v = 0; v < NV; v++) begin
      model(tv[v].trials, tv[v].seed, tv[v].mode);
      if (tv[v].exp_match < 0) tv[v].exp_match = m_match;
      tv[v].exp_guess = m_guess;
      tv[v].exp_in    = m_in;
      tv[v].exp_key   = m_key;
      for (int i = 0; i < KEY_W; i++) exp_hit[v][i] = m_hit[i];
    end

    // Reset held: start must be ignored and all outputs stay 0.
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.trials = '0;
    bus.seed = '0;
    bus.rd_idx = '0;
    repeat (2) @(negedge clk);
    bus.trials = 16'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_match", bus.match_cnt, 0);
    check("rst_guess", bus.key_guess, 0);
    check("rst_in", bus.dut_in, 0);
    check("rst_key", bus.dut_key, 0);
    check("rst_hit", bus.rd_hit, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_in", bus.dut_in, 0);
    check("post_rst_match", bus.match_cnt, 0);

    for (int v = 0; v < NV; v++) begin
      mode = tv[v].mode;
      start_and_wait(tv[v].trials, tv[v].seed, cyc);
      check($sformatf("v%0d_done_lat", v), cyc, tv[v].trials * TRIAL_CYC + 1);
      check($sformatf("v%0d_busy_at_done", v), bus.busy, 0);
      check($sformatf("v%0d_match", v), bus.match_cnt, tv[v].exp_match);
      check($sformatf("v%0d_guess", v), bus.key_guess, tv[v].exp_guess);
      if (tv[v].trials > 0) begin
        check($sformatf("v%0d_last_in", v), bus.dut_in, tv[v].exp_in);
        check($sformatf("v%0d_last_key", v), bus.dut_key, tv[v].exp_key);
      end
      if (tv[v].mode == 1 && tv[v].exp_match > 0)
        check($sformatf("v%0d_guess_bit5", v), bus.key_guess[5], 1);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", v), bus.done, 0);
      check($sformatf("v%0d_busy_idle", v), bus.busy, 0);
      for (int i = 0; i < KEY_W; i++) begin
        @(negedge clk);
        bus.rd_idx = 7'(i);
        @(posedge clk); #1;
        check($sformatf("v%0d_hit%0d", v, i), bus.rd_hit, exp_hit[v][i]);
        if (tv[v].mode == 1 && i == 5)
          check($sformatf("v%0d_hit5_eq_match", v), bus.rd_hit, bus.match_cnt);
      end
    end

    // Mid-run restart attempt, then async reset during SETTLE of trial 7.
    mode = 0;
    model(7, 32'h0BAD_F00D, 0);
    cap_in  = m_in;
    cap_key = m_key;
    @(negedge clk);
    bus.trials = 16'd50;
    bus.seed   = 32'h0BAD_F00D;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    done_seen = 1'b0;
    for (int c = 1; c <= 6 * TRIAL_CYC + WORDS + 1; c++) begin
      @(posedge clk); #1;
      if (bus.done) done_seen = 1'b1;
      bus.start = (c == 20);
    end
    check("abort_no_done_before", done_seen, 0);
    check("abort_busy_before", bus.busy, 1);
    check("abort_match_before", bus.match_cnt, 6);
    check("abort_in_trial7", bus.dut_in, cap_in);
    check("abort_key_trial7", bus.dut_key, cap_key);
    rst_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_match", bus.match_cnt, 0);
    check("abort_in", bus.dut_in, 0);
    check("abort_key", bus.dut_key, 0);
    check("abort_rdhit", bus.rd_hit, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.rd_idx = 7'(i);
      @(posedge clk); #1;
      if (bus.done) done_seen = 1'b1;
      check($sformatf("abort_hit%0d", i), bus.rd_hit, 0);
    end
    check("abort_no_done_after", done_seen, 0);

    start_and_wait(7, 32'h0BAD_F00D, cyc);
    check("replay_lat", cyc, 7 * TRIAL_CYC + 1);
    check("replay_in", bus.dut_in, cap_in);
    check("replay_key", bus.dut_key, cap_key);
    check("replay_match", bus.match_cnt, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stat_key_probe.md
# stat_key_probe

On-chip statistical key-probe harness for locked combinational circuits. It generates pseudo-random primary-input vectors and key candidates from an LFSR and drives them into a locked circuit and an oracle. Over a programmable number of trials it counts output matches and, per key bit, the matches seen with that bit at 1. From these counts it forms a majority key guess. It is the synthesizable, parametrised successor of the single-vector file-driven bench and sits beside the locked netlist.

## Interface
- IN_W, 32: primary-input width driven to circuit and oracle.
- KEY_W, 128: key width.
- OUT_W, 22: circuit/oracle output width.
- SETTLE, 2: cycles (≥1) that a vector is held before sampling.
- CNT_W, 16: trial/counter width.
- WORDS, derived ceil((IN_W+KEY_W)/32): LFSR words per trial.

- v_in1_v  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- trials  in  CNT_W  trial count, latched at start.
- seed  in  32  LFSR seed, latched at start; 0 is replaced by 32'h1.
- dut_in  out  IN_W  primary inputs to locked circuit and oracle.
- dut_key  out  KEY_W  key candidate to locked circuit.
- dut_out  in  OUT_W  locked-circuit response.
- oracle_out  in  OUT_W  oracle response to the same dut_in.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse at run completion.
- match_cnt  out  CNT_W  trials with dut_out == oracle_out.
- key_guess  out  KEY_W  majority guess, valid from done.
- rd_idx  in  clog2(KEY_W)  hit-counter select.
- rd_hit  out  CNT_W  hit counter[rd_idx], registered (1-cycle latency).

## Operation
- LFSR: 32-bit Galois, taps 32'h80200003, shift right, advanced once per GEN cycle.
- FSM states:
  - IDLE: start → latch trials/seed, clear match_cnt, all hit counters and trial counter, → GEN; start with trials==0 → FINAL.
  - GEN: WORDS cycles. Each cycle appends the current LFSR state to a vector shift register, first word in the LSBs. On the last GEN cycle, load dut_in = vector[IN_W-1:0] and dut_key = vector[IN_W+KEY_W-1:IN_W]. → SETTLE.
  - SETTLE: hold for SETTLE cycles. → SAMPLE.
  - SAMPLE: compare dut_out and oracle_out on all OUT_W bits. On a match: match_cnt+1, and hit[i]+1 for every i with dut_key[i]=1. Trial counter +1. If the count equals trials → FINAL, else → GEN.
  - FINAL: for each bit, key_guess[i] = (2*hit[i] > match_cnt). A tie or match_cnt==0 gives 0. Pulse done. → IDLE.
- No overflow handling is needed: hit[i] ≤ match_cnt ≤ trials ≤ 2^CNT_W−1.
- start while busy: ignored.
- dut_in, dut_key, match_cnt and key_guess hold their values in IDLE until the next accepted start. match_cnt and the hit counters are cleared at that start; key_guess is overwritten at the next FINAL.
- rd_hit is readable at any time; it shows live counts while busy.

## Timing
- Reset (async assert, sync release): state IDLE; dut_in, dut_key, busy, done, match_cnt, key_guess and rd_hit all 0; all hit counters 0; LFSR 32'h1.
- Reset mid-run aborts immediately and returns everything to the reset state. No done pulse is generated.
- Per trial: WORDS+SETTLE+1 cycles (defaults: 5+2+1 = 8).
- Start accepted at edge k:
  - busy=1 after edge k.
  - done high for the cycle following edge k + trials*(WORDS+SETTLE+1) + 1.
  - busy falls with done.
- trials==0: done one cycle after start edge, counts 0.
- dut_in/dut_key change only on the last-GEN edge. They are stable through SETTLE and SAMPLE; the circuit under test is purely combinational within that window.
- rd_hit reflects rd_idx from the previous edge.

## Test plan
- Reset: hold reset=0, pulse start → all outputs 0, busy stays 0; release reset, outputs remain 0 until start.
- trials=0, seed=5: start → done one cycle later, match_cnt=0, key_guess=0, busy low after.
- oracle_out wired to dut_out, trials=10, seed=32'hACE1 (defaults): done at start+81 cycles, match_cnt=10; each rd_hit[i] equals the reference-model popcount of key bit i over the 10 generated keys.
- dut_out = oracle_out ^ {OUT_W{~dut_key[5]}}, trials=256 → match_cnt = number of keys with bit5=1, rd_hit[5]=match_cnt, key_guess[5]=1; other bits match the model.
- dut_out = ~oracle_out, trials=20 → match_cnt=0, key_guess=0, all rd_hit=0.
- trials=50, pulse start again mid-run (ignored, counts unaffected), then assert reset during SETTLE of trial 7 → busy=0 and counters 0 immediately, no done; rerun with the same seed reproduces the first run's vectors exactly.
